// File: rtl/count_event_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : count_event_monitor_if
//  Purpose  : Event stream handshake between count_event_monitor (producer)
//             and a downstream consumer.
//  Signals  : evt_valid  head of event FIFO holds an entry
//             evt_ready  consumer accepts the head this cycle
//             evt_code   2-bit event code of the head entry
//             evt_value  counter value at which the head event occurred
//  Modports : master = producer (monitor), slave = consumer
//  Revision : 1.0 - initial release
// ============================================================================
interface count_event_monitor_if #(
  parameter int WIDTH = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_code;
  logic [WIDTH-1:0] evt_value;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_value,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_value,
    output evt_ready
  );
endinterface
`default_nettype wire

// File: rtl/count_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : count_event_monitor
//  Purpose  : Observes a loadable up/down counter, detects LOAD, WRAP_UP,
//             WRAP_DN and MATCH events, and queues them in a small FWFT
//             FIFO drained over a valid/ready handshake. Keeps a saturating
//             tally of wrap events.
//  Ports    : clk            rising-edge clock shared with the counter
//             rst            synchronous reset, active-low
//             i_cnt_q        counter output
//             i_cnt_load     counter load strobe
//             i_cnt_mode     counter direction (0 up, 1 down)
//             i_match_en     enables MATCH detection
//             i_match_val    MATCH compare value
//             evt            event stream (master side)
//             o_fifo_full    FIFO holds FIFO_DEPTH entries
//             o_overflow_err sticky: an event was dropped on a full FIFO
//             o_wrap_count   saturating count of wrap events
//  Revision : 1.0 - initial release
// ============================================================================
module count_event_monitor #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_CNT_W = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [WIDTH-1:0]      i_cnt_q,
  input  wire logic                  i_cnt_load,
  input  wire logic                  i_cnt_mode,
  input  wire logic                  i_match_en,
  input  wire logic [WIDTH-1:0]      i_match_val,
  count_event_monitor_if.master      evt,
  output logic                       o_fifo_full,
  output logic                       o_overflow_err,
  output logic [WRAP_CNT_W-1:0]      o_wrap_count
);

  localparam int                     c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                     c_OCC_W     = c_PTR_W + 1;
  localparam logic [c_OCC_W-1:0]     c_DEPTH     = c_OCC_W'(FIFO_DEPTH);
  localparam logic [1:0]             c_EVT_MATCH = 2'b00;
  localparam logic [1:0]             c_EVT_WUP   = 2'b01;
  localparam logic [1:0]             c_EVT_WDN   = 2'b10;
  localparam logic [1:0]             c_EVT_LOAD  = 2'b11;
  localparam logic [WIDTH-1:0]       c_ONES      = '1;
  localparam logic [WIDTH-1:0]       c_ZERO      = '0;
  localparam logic [WRAP_CNT_W-1:0]  c_WRAP_MAX  = '1;

  // Previous-sample state
  logic [WIDTH-1:0]      r_prev_q;
  logic                  r_load_d;
  logic                  r_mode_d;
  logic                  r_prev_valid;

  // FIFO state
  logic [WIDTH+1:0]      r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_OCC_W-1:0]    r_occ;
  logic                  r_full;

  // Status
  logic                  r_ovf;
  logic [WRAP_CNT_W-1:0] r_wrap;

  // Combinational
  logic                  w_hit;
  logic [1:0]            w_code;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_is_wrap;
  logic [c_OCC_W-1:0]    w_occ_nxt;
  logic [WIDTH+1:0]      w_head;
  logic                  w_valid;

  // --------------------------------------------------------------------------
  // Event detection. The if/else chain encodes LOAD > WRAP > MATCH priority,
  // so at most one event is produced per cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hit  = 1'b0;
    w_code = c_EVT_MATCH;
    if (r_prev_valid) begin
      if (r_load_d) begin
        w_hit  = 1'b1;
        w_code = c_EVT_LOAD;
      end else if (!r_mode_d && (r_prev_q == c_ONES) && (i_cnt_q == c_ZERO)) begin
        w_hit  = 1'b1;
        w_code = c_EVT_WUP;
      end else if (r_mode_d && (r_prev_q == c_ZERO) && (i_cnt_q == c_ONES)) begin
        w_hit  = 1'b1;
        w_code = c_EVT_WDN;
      end else if (i_match_en && (i_cnt_q == i_match_val) && (i_cnt_q != r_prev_q)) begin
        // Requiring a change in value turns a held match into a single event.
        w_hit  = 1'b1;
        w_code = c_EVT_MATCH;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control. A pop frees a slot in the same cycle, so a full FIFO can
  // accept a push when the head is being consumed.
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid   = (r_occ != '0);
    w_pop     = w_valid && evt.evt_ready;
    w_push    = w_hit && (!r_full || w_pop);
    w_drop    = w_hit && r_full && !w_pop;
    w_is_wrap = w_hit && ((w_code == c_EVT_WUP) || (w_code == c_EVT_WDN));
    w_occ_nxt = r_occ;
    if (w_push && !w_pop) begin
      w_occ_nxt = r_occ + c_OCC_W'(1);
    end else if (!w_push && w_pop) begin
      w_occ_nxt = r_occ - c_OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev_q     <= '0;
      r_load_d     <= 1'b0;
      r_mode_d     <= 1'b0;
      r_prev_valid <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_full       <= 1'b0;
      r_ovf        <= 1'b0;
      r_wrap       <= '0;
    end else begin
      r_prev_q     <= i_cnt_q;
      r_load_d     <= i_cnt_load;
      r_mode_d     <= i_cnt_mode;
      r_prev_valid <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_occ  <= w_occ_nxt;
      r_full <= (w_occ_nxt == c_DEPTH);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      // Wraps are tallied even when the FIFO drops the event.
      if (w_is_wrap && (r_wrap != c_WRAP_MAX)) begin
        r_wrap <= r_wrap + WRAP_CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while occupancy > 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_code, i_cnt_q};
    end
  end

  // Head is forced to zero while empty so outputs are clean after reset.
  always_comb begin
    w_head         = r_mem[r_rd_ptr];
    evt.evt_valid  = w_valid;
    evt.evt_code   = w_valid ? w_head[WIDTH+1:WIDTH] : 2'b00;
    evt.evt_value  = w_valid ? w_head[WIDTH-1:0]     : '0;
  end

  assign o_fifo_full    = r_full;
  assign o_overflow_err = r_ovf;
  assign o_wrap_count   = r_wrap;

endmodule
`default_nettype wire

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
Downstream observer for the loadable up/down counter. Samples the counter output with its load and mode strobes. Detects wrap-up, wrap-down, load and match events, and queues them in a small first-word-fall-through (FWFT) event FIFO. A consumer drains the FIFO over a valid/ready handshake. The block also keeps a saturating wrap tally for status reads.

Parameters:
WIDTH, 4, width of the counter value being monitored
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
WRAP_CNT_W, 8, width of saturating wrap tally

Ports:
clk  input  1  rising-edge clock, shared with counter
rst  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge)
cnt_q  input  WIDTH  counter output q
cnt_load  input  1  counter load strobe (same signal that drives counter)
cnt_mode  input  1  counter direction: 0 = up, 1 = down
match_en  input  1  enables MATCH detection
match_val  input  WIDTH  compare value for MATCH
evt_valid  output  1  FIFO head holds an event
evt_ready  input  1  consumer accepts head this cycle
evt_code  output  2  head event: 00 MATCH, 01 WRAP_UP, 10 WRAP_DN, 11 LOAD
evt_value  output  WIDTH  cnt_q value at which the event occurred
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
overflow_err  output  1  sticky: an event was dropped because the FIFO was full
wrap_count  output  WRAP_CNT_W  saturating count of WRAP_UP + WRAP_DN events

Behaviour:
- Reset (rst=0 at an edge) applies to all state.
  - prev_q=0, load_d=0, mode_d=0, prev_valid=0.
  - FIFO emptied; evt_valid=0, evt_code=0, evt_value=0, fifo_full=0.
  - overflow_err=0, wrap_count=0.
  - Reset mid-operation discards all queued and pending events.
- Sampling, every edge with rst=1:
  - prev_q<=cnt_q, load_d<=cnt_load, mode_d<=cnt_mode, prev_valid<=1.
  - load_d and mode_d are therefore the strobes that caused the transition into the current cnt_q.
- Combinational detection, only when prev_valid=1:
  - LOAD: load_d=1. Fires even if the loaded value equals prev_q.
  - WRAP_UP: load_d=0, mode_d=0, prev_q=all-ones, cnt_q=0.
  - WRAP_DN: load_d=0, mode_d=1, prev_q=0, cnt_q=all-ones.
  - MATCH: match_en=1, cnt_q=match_val, cnt_q!=prev_q. A held value yields a single MATCH.
  - Priority: LOAD > WRAP_UP/WRAP_DN > MATCH. At most one event per cycle; lower-priority hits that cycle are discarded.
  - First sample after reset release: prev_valid=0, so no event.
- Push:
  - The detected event {code, cnt_q} is written into the FIFO at the same edge that updates prev_q.
  - evt_valid rises in the cycle after that edge if the FIFO was empty.
  - Latency: cnt_q change to evt_valid is 1 clk. There is no combinational bypass.
- Pop: occurs at an edge where evt_valid=1 and evt_ready=1. evt_code/evt_value must hold stable while evt_valid=1 and evt_ready=0.
- Full FIFO:
  - push with no pop: event dropped, overflow_err<=1 (sticky until reset).
  - push with pop in the same cycle: both occur, no drop, occupancy unchanged.
- Empty FIFO:
  - a pop request is ignored.
  - push and evt_ready together: entry written, evt_valid=1 next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_full is registered and consistent with occupancy every cycle.
- wrap_count:
  - increments on every detected WRAP_UP/WRAP_DN, whether or not the FIFO dropped the event.
  - saturates at 2^WRAP_CNT_W-1.
- cnt_load and cnt_mode changing together: load_d governs, so LOAD is reported.

Test Plan:
1. WRAP_UP: rst=0 for 1 clk, then rst=1, mode=0, counter runs 0..15,0 with evt_ready=1 -> exactly one event {01, 0}, one cycle after q=0 appears; wrap_count=1.
2. WRAP_DN: load 2, then mode=1, q=2,1,0,15 -> events {11, 2} then {10, 15}; wrap_count=1.
3. Load then wrap: load=1 with in=4'b1110 for 1 clk, then mode=0 -> {11, 14}, then {01, 0} after q goes 15 -> 0.
4. MATCH: match_en=1, match_val=5, up-count; separately hold q=5 for 3 clks -> a single {00, 5} per pass. With match_val=0 at the up-wrap, only {01, 0} is reported.
5. Full FIFO: evt_ready=0, generate 5 events -> fifo_full=1 after the 4th; 5th dropped; overflow_err=1. Then evt_ready=1 drains 4 entries in order; evt_valid=0 after; overflow_err stays 1.
6. Reset mid-drain: rst=0 for 1 clk with 3 entries queued -> next cycle evt_valid=0, fifo_full=0, wrap_count=0, overflow_err=0. No event on the first post-reset sample even if cnt_q=match_val.
